// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, line levels
// and the stop-bit count (two stop bits when UART_TX_STOP2_EN is defined).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_STOP2_EN
    localparam int unsigned STOP_BITS = 2;
`else
    localparam int unsigned STOP_BITS = 1;
`endif

    // Counter width for a count of 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load-enabled right-shift register with a bit counter that flags the last data bit.
// bit_o always presents the LSB still waiting to go out on the line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  shift_i,
    input  logic                  cnt_en_i,
    output logic                  bit_o,
    output logic                  last_o
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (load_i) begin
                shift_q <= data_i;
            end else if (shift_i) begin
                shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            end
            // Counter tracks the bit currently on the line while in DATA.
            if (cnt_en_i) begin
                cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign bit_o  = shift_q[0];
    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/busy accept, parity capture, frame FSM and
// registered line driver. Define UART_TX_STOP2_EN for two stop bits.
//
// Handshake: a word is taken on any rising edge where Data_Valid is high and
// Busy is low; Data_Valid while Busy is high is dropped without any side effect.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PARITY_BIT,
    output logic                  TX_OUT,
    output logic                  Busy,
    output uart_state_e           dbg_state_o
);

    uart_state_e state_q, state_d;
    logic        tx_q;
    logic        busy_q;
    logic        par_q;
    logic        par_en_q;
    logic        accept;
    logic        ser_bit;
    logic        ser_last;
    logic        stop_last;

    assign accept = Data_Valid && !busy_q;

`ifdef UART_TX_STOP2_EN
    logic stop_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= (state_q == ST_STOP) && (state_d == ST_STOP);
        end
    end

    assign stop_last = stop_cnt_q;
`else
    assign stop_last = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  state_d = ST_DATA;
            ST_DATA:   if (ser_last) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
                if (stop_last) state_d = accept ? ST_START : ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .load_i   (accept),
        .data_i   (P_DATA),
        .shift_i  (state_d == ST_DATA),
        .cnt_en_i (state_q == ST_DATA),
        .bit_o    (ser_bit),
        .last_o   (ser_last)
    );

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                par_q    <= PARITY_BIT;
                par_en_q <= PAR_EN;
            end
            case (state_d)
                ST_START: begin
                    tx_q   <= START_BIT;
                    busy_q <= 1'b1;
                end
                ST_DATA: begin
                    tx_q   <= ser_bit;
                    busy_q <= 1'b1;
                end
                ST_PARITY: begin
                    tx_q   <= par_q;
                    busy_q <= 1'b1;
                end
                ST_STOP: begin
                    // Busy falls in the final stop cycle so the next word can be taken.
                    tx_q   <= STOP_BIT;
                    busy_q <= (STOP_BITS > 1) && (state_q != ST_STOP);
                end
                default: begin
                    tx_q   <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT      = tx_q;
    assign Busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (default build, one stop bit, DATA_WIDTH=8).
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic        CLK;
    logic        RST;
    logic [7:0]  P_DATA;
    logic        Data_Valid;
    logic        PAR_EN;
    logic        PARITY_BIT;
    logic        TX_OUT;
    logic        Busy;
    uart_state_e dbg_state;

    int n_tests;
    int n_fail;

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .PAR_EN      (PAR_EN),
        .PARITY_BIT  (PARITY_BIT),
        .TX_OUT      (TX_OUT),
        .Busy        (Busy),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle tx"}, 32'(TX_OUT), 32'd1);
        check({tag, " idle busy"}, 32'(Busy), 32'd0);
        check({tag, " idle state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Per-test input changes applied right after the checks of frame cycle i.
    task automatic mid_action(input int tid, input int i);
        case (tid)
            1, 3: if (i == 0) Data_Valid = 1'b0;
            2: if (i == 0) begin
                Data_Valid = 1'b0;
                P_DATA     = 8'hFF;
                PARITY_BIT = 1'b0;
                PAR_EN     = 1'b0;
            end
            4: begin
                if (i == 0)  P_DATA = 8'h80;
                if (i == 10) Data_Valid = 1'b0;
            end
            5: begin
                if (i == 0) Data_Valid = 1'b0;
                if (i == 4) begin
                    Data_Valid = 1'b1;
                    P_DATA     = 8'h55;
                end
                if (i == 5) Data_Valid = 1'b0;
            end
            default: ;
        endcase
    endtask

    // Called at a negedge with the accepting inputs already driven; checks one
    // character of each expected string per cycle, starting at the start bit.
    task automatic play(input int tid, input string tag, input string tx_exp, input string busy_exp);
        @(negedge CLK);
        for (int i = 0; i < tx_exp.len(); i++) begin
            check($sformatf("%s tx[%0d]", tag, i), 32'(TX_OUT), 32'(tx_exp[i] == "1"));
            check($sformatf("%s busy[%0d]", tag, i), 32'(Busy), 32'(busy_exp[i] == "1"));
            mid_action(tid, i);
            @(negedge CLK);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PARITY_BIT = 1'b0;

        repeat (3) @(negedge CLK);
        check_idle("reset");
        RST = 1'b1;
        @(negedge CLK);
        check_idle("post_reset");

        // 0xA5, even parity (0)
        P_DATA = 8'hA5; PAR_EN = 1'b1; PARITY_BIT = 1'b0; Data_Valid = 1'b1;
        play(1, "a5_even", "01010010101", "11111111110");
        check_idle("a5_even");

        // 0xA5, odd parity (1); inputs scrambled after accept
        P_DATA = 8'hA5; PAR_EN = 1'b1; PARITY_BIT = 1'b1; Data_Valid = 1'b1;
        play(2, "a5_odd", "01010010111", "11111111110");
        check_idle("a5_odd");

        // 0x3C without parity
        P_DATA = 8'h3C; PAR_EN = 1'b0; PARITY_BIT = 1'b1; Data_Valid = 1'b1;
        play(3, "3c_nopar", "0001111001", "1111111110");
        check_idle("3c_nopar");

        // back-to-back 0x01 then 0x80
        P_DATA = 8'h01; PAR_EN = 1'b0; PARITY_BIT = 1'b0; Data_Valid = 1'b1;
        play(4, "b2b", "01000000010000000011", "11111111101111111110");
        check_idle("b2b");

        // 0x55 pulse during DATA of a 0xA5 frame is dropped
        P_DATA = 8'hA5; PAR_EN = 1'b0; PARITY_BIT = 1'b0; Data_Valid = 1'b1;
        play(5, "pulse", "0101001011", "1111111110");
        check_idle("pulse");
        @(negedge CLK);
        check_idle("pulse_late");

        // asynchronous reset in the middle of DATA
        P_DATA = 8'hA5; PAR_EN = 1'b1; PARITY_BIT = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_mid in_data", 32'(dbg_state), 32'(ST_DATA));
        #2 RST = 1'b0;
        #1;
        check("rst_mid tx", 32'(TX_OUT), 32'd1);
        check("rst_mid busy", 32'(Busy), 32'd0);
        check("rst_mid state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_idle("rst_release");

        P_DATA = 8'h3C; PAR_EN = 1'b0; PARITY_BIT = 1'b0; Data_Valid = 1'b1;
        play(3, "after_rst", "0001111001", "1111111110");
        check_idle("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
